// File: rtl/tinyml_cmd_router_pkg.sv
`default_nettype none
//==============================================================================
// Module : tinyml_cmd_router_pkg
// Brief  : Shared target encoding, field positions and widths for the router.
// Rev    : 1.0
//==============================================================================
package tinyml_cmd_router_pkg;

  typedef enum logic {
    TGT_ACC = 1'b0,
    TGT_USR = 1'b1
  } tgt_e;

  localparam int FID_SEL_BIT         = 9;
  localparam int c_FID_W             = 10;
  localparam int c_DATA_W            = 32;
  localparam int c_ORD_DEPTH_DEFAULT = 4;

  function automatic tgt_e fid_target(input logic [c_FID_W-1:0] fid);
    return tgt_e'(fid[FID_SEL_BIT]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tinyml_cmd_router_if.sv
`default_nettype none
//==============================================================================
// Module : tinyml_cmd_router_if
// Brief  : One command/response channel; master issues commands, slave answers.
// Rev    : 1.0
//==============================================================================
interface tinyml_cmd_router_if;
  import tinyml_cmd_router_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [c_FID_W-1:0]  cmd_function_id;
  logic [c_DATA_W-1:0] cmd_inputs_0;
  logic [c_DATA_W-1:0] cmd_inputs_1;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [c_DATA_W-1:0] rsp_outputs_0;

  modport master (
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_outputs_0
  );

endinterface
`default_nettype wire

// File: rtl/tinyml_order_fifo.sv
`default_nettype none
//==============================================================================
// Module : tinyml_order_fifo
// Brief  : 1-bit target-order FIFO remembering which target owns each command.
// Rev    : 1.0
//==============================================================================
module tinyml_order_fifo
  import tinyml_cmd_router_pkg::*;
#(
  parameter int ORD_DEPTH = c_ORD_DEPTH_DEFAULT
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       i_push,
  input  wire tgt_e                       i_push_tgt,
  input  wire logic                       i_pop,
  output tgt_e                            o_head,
  output logic                            o_full,
  output logic                            o_empty,
  output logic [$clog2(ORD_DEPTH):0]      o_count
);

  localparam int c_PTR_W = $clog2(ORD_DEPTH);

  tgt_e               r_mem [ORD_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Guarded so a misbehaving caller can never over- or under-run the count.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_tgt;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (c_PTR_W+1)'(ORD_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/tinyml_cmd_router.sv
`default_nettype none
//==============================================================================
// Module : tinyml_cmd_router
// Brief  : Routes CPU commands to accel/user targets, returns responses in order.
// Rev    : 1.0
//==============================================================================
module tinyml_cmd_router
  import tinyml_cmd_router_pkg::*;
#(
  parameter int ORD_DEPTH = c_ORD_DEPTH_DEFAULT
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  tinyml_cmd_router_if.slave         cpu,
  tinyml_cmd_router_if.master        acc,
  tinyml_cmd_router_if.master        usr,
  output logic [$clog2(ORD_DEPTH):0] outstanding
);

  tgt_e                w_sel;
  tgt_e                w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_out_free;
  logic [c_DATA_W-1:0] w_rsp_data;
  logic                r_rsp_valid;
  logic [c_DATA_W-1:0] r_rsp_data;

  assign w_sel = fid_target(cpu.cmd_function_id);

  assign acc.cmd_valid       = cpu.cmd_valid & (w_sel == TGT_ACC) & ~w_full;
  assign usr.cmd_valid       = cpu.cmd_valid & (w_sel == TGT_USR) & ~w_full;
  assign acc.cmd_function_id = cpu.cmd_function_id;
  assign acc.cmd_inputs_0    = cpu.cmd_inputs_0;
  assign acc.cmd_inputs_1    = cpu.cmd_inputs_1;
  assign usr.cmd_function_id = cpu.cmd_function_id;
  assign usr.cmd_inputs_0    = cpu.cmd_inputs_0;
  assign usr.cmd_inputs_1    = cpu.cmd_inputs_1;

  // Full blocks acceptance even when a pop frees a slot this same cycle.
  assign cpu.cmd_ready = ~w_full & ((w_sel == TGT_USR) ? usr.cmd_ready : acc.cmd_ready);
  assign w_push        = cpu.cmd_valid & cpu.cmd_ready;

  // Only the target at the FIFO head may deliver, keeping issue order.
  assign w_out_free    = ~r_rsp_valid | cpu.rsp_ready;
  assign acc.rsp_ready = ~w_empty & (w_head == TGT_ACC) & w_out_free;
  assign usr.rsp_ready = ~w_empty & (w_head == TGT_USR) & w_out_free;
  assign w_pop         = (acc.rsp_valid & acc.rsp_ready) | (usr.rsp_valid & usr.rsp_ready);
  assign w_rsp_data    = (w_head == TGT_USR) ? usr.rsp_outputs_0 : acc.rsp_outputs_0;

  tinyml_order_fifo #(
    .ORD_DEPTH (ORD_DEPTH)
  ) u_order_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_tgt (w_sel),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (outstanding)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_pop) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_rsp_data;
    end else if (cpu.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign cpu.rsp_valid     = r_rsp_valid;
  assign cpu.rsp_outputs_0 = r_rsp_data;

endmodule
`default_nettype wire
